// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Start/busy/done handshake with held result and overflow for values >= 10^DIGITS.
module bin2bcd_seq #(
  parameter int unsigned BIN_WIDTH = 6,
  parameter int unsigned DIGITS    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned CntWidth = $clog2(BIN_WIDTH + 1);
  localparam int unsigned BcdWidth = 4 * DIGITS;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                state_q;
  logic [BIN_WIDTH-1:0]  shift_q;
  logic [BcdWidth-1:0]   work_q;
  logic [BcdWidth-1:0]   work_corr;
  logic [BcdWidth-1:0]   work_next;
  logic                  sticky_q;
  logic                  carry_out;
  logic [CntWidth-1:0]   cnt_q;
  logic                  last_shift;

  // Per-digit add-3 correction; digits are independent, no carry between them.
  always_comb begin
    work_corr = work_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (work_q[4*k +: 4] >= 4'd5) begin
        work_corr[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // The bit leaving the top digit is worth a multiple of 10^DIGITS.
  assign carry_out  = work_corr[BcdWidth-1];
  assign work_next  = {work_corr[BcdWidth-2:0], shift_q[BIN_WIDTH-1]};
  assign last_shift = (cnt_q == CntWidth'(BIN_WIDTH - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      work_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            shift_q  <= binary;
            work_q   <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= StShift;
          end
        end
        StShift: begin
          work_q   <= work_next;
          shift_q  <= shift_q << 1;
          sticky_q <= sticky_q | carry_out;
          cnt_q    <= cnt_q + 1'b1;
          if (last_shift) begin
            bcd      <= work_next;
            overflow <= sticky_q | carry_out;
            done     <= 1'b1;
            busy     <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq over four width/digit configurations.
module tb_bin2bcd_seq;

  typedef struct {
    int          id;
    logic [39:0] bcd;
    logic        ovf;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_s [4];
  logic [31:0] bin_s   [4];
  logic        busy_w  [4];
  logic        done_w  [4];
  logic        ovf_w   [4];
  logic [39:0] bcd_w   [4];
  logic [7:0]  bcd_a;
  logic [11:0] bcd_b;
  logic [7:0]  bcd_c;
  logic [39:0] bcd_d;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  bin2bcd_seq #(.BIN_WIDTH(6), .DIGITS(2)) u_a (
    .clock(clock), .reset(reset), .start(start_s[0]), .binary(bin_s[0][5:0]),
    .busy(busy_w[0]), .done(done_w[0]), .bcd(bcd_a), .overflow(ovf_w[0])
  );
  bin2bcd_seq #(.BIN_WIDTH(8), .DIGITS(3)) u_b (
    .clock(clock), .reset(reset), .start(start_s[1]), .binary(bin_s[1][7:0]),
    .busy(busy_w[1]), .done(done_w[1]), .bcd(bcd_b), .overflow(ovf_w[1])
  );
  bin2bcd_seq #(.BIN_WIDTH(8), .DIGITS(2)) u_c (
    .clock(clock), .reset(reset), .start(start_s[2]), .binary(bin_s[2][7:0]),
    .busy(busy_w[2]), .done(done_w[2]), .bcd(bcd_c), .overflow(ovf_w[2])
  );
  bin2bcd_seq #(.BIN_WIDTH(32), .DIGITS(10)) u_d (
    .clock(clock), .reset(reset), .start(start_s[3]), .binary(bin_s[3]),
    .busy(busy_w[3]), .done(done_w[3]), .bcd(bcd_d), .overflow(ovf_w[3])
  );

  assign bcd_w[0] = {32'd0, bcd_a};
  assign bcd_w[1] = {28'd0, bcd_b};
  assign bcd_w[2] = {32'd0, bcd_c};
  assign bcd_w[3] = bcd_d;

  function automatic int digits_of(input int id);
    case (id)
      0: return 2;
      1: return 3;
      2: return 2;
      default: return 10;
    endcase
  endfunction

  // Reference: decimal digits of v mod 10^D, overflow when v >= 10^D.
  function automatic exp_t model(input int id, input longint unsigned v);
    exp_t e;
    longint unsigned p = 1;
    longint unsigned r;
    for (int d = 0; d < digits_of(id); d++) p = p * 10;
    e.id  = id;
    e.ovf = (v >= p);
    e.bcd = '0;
    r     = v % p;
    for (int d = 0; d < digits_of(id); d++) begin
      e.bcd[4*d +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return e;
  endfunction

  // Pulses start for one edge (the accepting edge) and records the expectation.
  task automatic launch(input int id, input longint unsigned v);
    sb.push_back(model(id, v));
    start_s[id] = 1'b1;
    bin_s[id]   = v[31:0];
    @(posedge clock); #1;
    start_s[id] = 1'b0;
  endtask

  // Waits for done; returns edges elapsed, busy samples seen and bcd stability.
  task automatic wait_done(input int id, output int cyc, output int busy_cnt,
                           output bit stable);
    logic [39:0] hold;
    hold     = bcd_w[id];
    cyc      = 0;
    busy_cnt = 0;
    stable   = 1'b1;
    while (done_w[id] !== 1'b1 && cyc < 100) begin
      if (busy_w[id] === 1'b1) busy_cnt++;
      if (bcd_w[id] !== hold) stable = 1'b0;
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_s[i] = 1'b0;
      bin_s[i]   = '0;
    end
    #2;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (busy_w[i] !== 1'b0 || done_w[i] !== 1'b0 || ovf_w[i] !== 1'b0 ||
          bcd_w[i] !== 40'd0) begin
        n_bad++;
        $display("FAIL reset_state id%0d: got busy=%b done=%b ovf=%b bcd=%h, want 0/0/0/0",
                 i, busy_w[i], done_w[i], ovf_w[i], bcd_w[i]);
      end
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_defaults();
    exp_t e;
    int cyc, bc;
    bit st;
    launch(0, 63);
    wait_done(0, cyc, bc, st);
    e = sb.pop_front();
    n_vec++;
    if (cyc !== 6) begin
      n_bad++; $display("FAIL def63_latency: got %0d, want 6", cyc);
    end
    n_vec++;
    if (bc !== 6) begin
      n_bad++; $display("FAIL def63_busy_cycles: got %0d, want 6", bc);
    end
    n_vec++;
    if (!st) begin
      n_bad++; $display("FAIL def63_bcd_hold: got changed, want stable");
    end
    n_vec++;
    if (bcd_w[0] !== e.bcd || ovf_w[0] !== e.ovf || busy_w[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL def63_result: got bcd=%h ovf=%b busy=%b, want bcd=%h ovf=%b busy=0",
               bcd_w[0], ovf_w[0], busy_w[0], e.bcd, e.ovf);
    end
    @(posedge clock); #1;
    n_vec++;
    if (done_w[0] !== 1'b0 || bcd_w[0] !== e.bcd) begin
      n_bad++;
      $display("FAIL def63_done_pulse: got done=%b bcd=%h, want done=0 bcd=%h",
               done_w[0], bcd_w[0], e.bcd);
    end
    launch(0, 0);
    wait_done(0, cyc, bc, st);
    e = sb.pop_front();
    n_vec++;
    if (cyc !== 6 || bcd_w[0] !== e.bcd || ovf_w[0] !== e.ovf) begin
      n_bad++;
      $display("FAIL def0_result: got lat=%0d bcd=%h ovf=%b, want lat=6 bcd=%h ovf=%b",
               cyc, bcd_w[0], ovf_w[0], e.bcd, e.ovf);
    end
  endtask

  task automatic test_sweep();
    exp_t e;
    int cyc, bc;
    bit st;
    for (int v = 0; v < 256; v++) begin
      launch(1, longint'(v));
      wait_done(1, cyc, bc, st);
      e = sb.pop_front();
      n_vec++;
      if (cyc !== 8) begin
        n_bad++; $display("FAIL sweep_latency v=%0d: got %0d, want 8", v, cyc);
      end
      n_vec++;
      if (bcd_w[1] !== e.bcd || ovf_w[1] !== e.ovf) begin
        n_bad++;
        $display("FAIL sweep_result v=%0d: got bcd=%h ovf=%b, want bcd=%h ovf=%b",
                 v, bcd_w[1], ovf_w[1], e.bcd, e.ovf);
      end
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    int cyc, bc;
    bit st;
    longint unsigned vals [3] = '{255, 99, 100};
    for (int i = 0; i < 3; i++) begin
      launch(2, vals[i]);
      wait_done(2, cyc, bc, st);
      e = sb.pop_front();
      n_vec++;
      if (cyc !== 8 || bcd_w[2] !== e.bcd || ovf_w[2] !== e.ovf) begin
        n_bad++;
        $display("FAIL ovf_result v=%0d: got lat=%0d bcd=%h ovf=%b, want lat=8 bcd=%h ovf=%b",
                 vals[i], cyc, bcd_w[2], ovf_w[2], e.bcd, e.ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc, bc;
    bit st;
    launch(0, 42);
    @(posedge clock); #1;
    @(posedge clock); #1;
    // Third busy cycle: this start must be ignored.
    start_s[0] = 1'b1;
    bin_s[0]   = 17;
    @(posedge clock); #1;
    start_s[0] = 1'b0;
    bin_s[0]   = 0;
    wait_done(0, cyc, bc, st);
    e = sb.pop_front();
    n_vec++;
    if (cyc + 3 !== 6 || bcd_w[0] !== e.bcd || ovf_w[0] !== e.ovf) begin
      n_bad++;
      $display("FAIL b2b_ignored: got lat=%0d bcd=%h ovf=%b, want lat=6 bcd=%h ovf=%b",
               cyc + 3, bcd_w[0], ovf_w[0], e.bcd, e.ovf);
    end
    launch(0, 17);
    n_vec++;
    if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept: got done=%b busy=%b, want done=0 busy=1",
               done_w[0], busy_w[0]);
    end
    wait_done(0, cyc, bc, st);
    e = sb.pop_front();
    n_vec++;
    if (cyc + 1 !== 7 || bcd_w[0] !== e.bcd || ovf_w[0] !== e.ovf) begin
      n_bad++;
      $display("FAIL b2b_second: got gap=%0d bcd=%h ovf=%b, want gap=7 bcd=%h ovf=%b",
               cyc + 1, bcd_w[0], ovf_w[0], e.bcd, e.ovf);
    end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    int cyc, bc;
    bit st;
    int stray;
    launch(0, 57);
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    void'(sb.pop_back());
    #1;
    n_vec++;
    if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || ovf_w[0] !== 1'b0 ||
        bcd_w[0] !== 40'd0) begin
      n_bad++;
      $display("FAIL midreset_state: got busy=%b done=%b ovf=%b bcd=%h, want 0/0/0/0",
               busy_w[0], done_w[0], ovf_w[0], bcd_w[0]);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) stray++;
    end
    n_vec++;
    if (stray !== 0) begin
      n_bad++; $display("FAIL midreset_no_done: got %0d active cycles, want 0", stray);
    end
    launch(0, 57);
    wait_done(0, cyc, bc, st);
    e = sb.pop_front();
    n_vec++;
    if (cyc !== 6 || bcd_w[0] !== e.bcd || ovf_w[0] !== e.ovf) begin
      n_bad++;
      $display("FAIL midreset_rerun: got lat=%0d bcd=%h ovf=%b, want lat=6 bcd=%h ovf=%b",
               cyc, bcd_w[0], ovf_w[0], e.bcd, e.ovf);
    end
  endtask

  task automatic test_wide();
    exp_t e;
    int cyc, bc;
    bit st;
    launch(3, 64'd4294967295);
    wait_done(3, cyc, bc, st);
    e = sb.pop_front();
    n_vec++;
    if (cyc !== 32 || bc !== 32) begin
      n_bad++; $display("FAIL wide_latency: got lat=%0d busy=%0d, want 32/32", cyc, bc);
    end
    n_vec++;
    if (bcd_w[3] !== e.bcd || ovf_w[3] !== e.ovf) begin
      n_bad++;
      $display("FAIL wide_result: got bcd=%h ovf=%b, want bcd=%h ovf=%b",
               bcd_w[3], ovf_w[3], e.bcd, e.ovf);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_sweep();
    test_overflow();
    test_back_to_back();
    test_reset_midflight();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
